// File: rtl/elevator_plant_pkg.sv
// ============================================================================
// elevator_plant_pkg : shared door encodings and floor constants for the plant
// Rev 1.0
// ============================================================================
`default_nettype none

package elevator_plant_pkg;

    localparam int c_NUM_FLOORS = 3;
    localparam int c_FLOOR_0    = 0;
    localparam int c_FLOOR_1    = 1;
    localparam int c_FLOOR_2    = 2;

    typedef enum logic [1:0] {
        DOOR_CLOSED  = 2'd0,
        DOOR_OPENING = 2'd1,
        DOOR_OPEN    = 2'd2,
        DOOR_CLOSING = 2'd3
    } door_state_t;

endpackage

`default_nettype wire

// File: rtl/elevator_plant_door.sv
// ============================================================================
// elevator_door : cabin door FSM with open/close timer and R completion strobe
// Rev 1.0
// ============================================================================
`default_nettype none

module elevator_door
    import elevator_plant_pkg::*;
#(
    parameter int DOOR_CYCLES = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        P,
    input  logic        M,
    input  logic        at_floor,
    output door_state_t o_state,
    output logic        o_r,
    output logic        o_door_closed
);

    localparam int TW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [TW-1:0] c_RELOAD = TW'(DOOR_CYCLES - 1);

    door_state_t     r_state, w_state_nxt;
    logic [TW-1:0]   r_timer, w_timer_nxt;
    logic            r_r, w_r_nxt;
    logic            r_door_closed;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state       <= DOOR_CLOSED;
            r_timer       <= '0;
            r_r           <= 1'b0;
            r_door_closed <= 1'b1;
        end else begin
            r_state       <= w_state_nxt;
            r_timer       <= w_timer_nxt;
            r_r           <= w_r_nxt;
            r_door_closed <= (w_state_nxt == DOOR_CLOSED);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_r_nxt     = 1'b0;
        case (r_state)
            DOOR_CLOSED: begin
                // Motion has priority over a door request at a floor
                if (P && !M && at_floor) begin
                    w_state_nxt = DOOR_OPENING;
                    w_timer_nxt = c_RELOAD;
                end
            end
            DOOR_OPENING: begin
                if (r_timer == '0) w_state_nxt = DOOR_OPEN;
                else               w_timer_nxt = r_timer - 1'b1;
            end
            DOOR_OPEN: begin
                if (!P) begin
                    w_state_nxt = DOOR_CLOSING;
                    w_timer_nxt = c_RELOAD;
                end
            end
            DOOR_CLOSING: begin
                if (P) begin
                    w_state_nxt = DOOR_OPENING;
                    w_timer_nxt = c_RELOAD;
                end else if (r_timer == '0) begin
                    w_state_nxt = DOOR_CLOSED;
                    w_r_nxt     = 1'b1;
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end
            default: w_state_nxt = DOOR_CLOSED;
        endcase
    end

    assign o_state       = r_state;
    assign o_r           = r_r;
    assign o_door_closed = r_door_closed;

endmodule

`default_nettype wire

// File: rtl/elevator_plant.sv
// ============================================================================
// elevator_plant : 3-floor cabin/shaft model closing the loop for the controller
// Optional macro ELEVATOR_PLANT_FAULT_EN enables the sticky Fault flag. Rev 1.0
// ============================================================================
`default_nettype none

module elevator_plant
    import elevator_plant_pkg::*;
#(
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 4,
    parameter int START_FLOOR   = 0
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       M,
    input  logic       D,
    input  logic       P,
    output logic       S0,
    output logic       S1,
    output logic       S2,
    output logic       R,
    output logic       DoorClosed,
    output logic [1:0] Floor,
    output logic       Fault
);

    localparam int POS_W = $clog2(2*TRAVEL_CYCLES + 1);
    localparam logic [POS_W-1:0]        c_POS_MAX  = POS_W'(2*TRAVEL_CYCLES);
    localparam logic [POS_W-1:0]        c_POS_RST  = POS_W'(START_FLOOR*TRAVEL_CYCLES);
    localparam logic [c_NUM_FLOORS-1:0] c_SENS_RST = c_NUM_FLOORS'(1) << START_FLOOR;

    logic [POS_W-1:0]        r_pos, w_pos_nxt;
    logic [c_NUM_FLOORS-1:0] r_sens, w_sens_nxt;
    logic [1:0]              r_floor, w_floor_nxt;
    door_state_t             w_door_state;
    logic                    w_move;

    elevator_door #(
        .DOOR_CYCLES (DOOR_CYCLES)
    ) u_door (
        .Clk           (Clk),
        .Reset         (Reset),
        .P             (P),
        .M             (M),
        .at_floor      (|r_sens),
        .o_state       (w_door_state),
        .o_r           (R),
        .o_door_closed (DoorClosed)
    );

    // Motor only acts with the door closed; the shaft ends clamp, never wrap
    assign w_move = M && (w_door_state == DOOR_CLOSED);

    always_comb begin
        w_pos_nxt = r_pos;
        if (w_move) begin
            if (D && (r_pos != c_POS_MAX))  w_pos_nxt = r_pos + 1'b1;
            else if (!D && (r_pos != '0))   w_pos_nxt = r_pos - 1'b1;
        end
    end

    always_comb begin
        w_sens_nxt  = '0;
        w_floor_nxt = r_floor;
        for (int k = 0; k < c_NUM_FLOORS; k++) begin
            if (w_pos_nxt == POS_W'(k*TRAVEL_CYCLES)) begin
                w_sens_nxt[k] = 1'b1;
                w_floor_nxt   = 2'(k);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_pos   <= c_POS_RST;
            r_sens  <= c_SENS_RST;
            r_floor <= 2'(START_FLOOR);
        end else begin
            r_pos   <= w_pos_nxt;
            r_sens  <= w_sens_nxt;
            r_floor <= w_floor_nxt;
        end
    end

    assign S0    = r_sens[c_FLOOR_0];
    assign S1    = r_sens[c_FLOOR_1];
    assign S2    = r_sens[c_FLOOR_2];
    assign Floor = r_floor;

`ifdef ELEVATOR_PLANT_FAULT_EN
    logic r_fault;
    logic w_fault_interlock;
    logic w_fault_overtravel;

    assign w_fault_interlock  = M && (w_door_state != DOOR_CLOSED);
    assign w_fault_overtravel = M && (((r_pos == '0) && !D) || ((r_pos == c_POS_MAX) && D));

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_fault <= 1'b0;
        end else if (w_fault_interlock || w_fault_overtravel) begin
            r_fault <= 1'b1;
            if (!r_fault)
                $display("%0t elevator_plant: Fault set, cause=%s", $time,
                         w_fault_interlock ? "door interlock" : "end-stop overtravel");
        end
    end

    assign Fault = r_fault;
`else
    assign Fault = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_elevator_plant.sv
// ============================================================================
// tb_elevator_plant : directed self-checking bench for elevator_plant defaults
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_elevator_plant;

    logic       Clk;
    logic       Reset;
    logic       M;
    logic       D;
    logic       P;
    logic       S0;
    logic       S1;
    logic       S2;
    logic       R;
    logic       DoorClosed;
    logic [1:0] Floor;
    logic       Fault;

    int n_checks = 0;
    int n_errors = 0;

`ifdef ELEVATOR_PLANT_FAULT_EN
    localparam logic c_FAULT_EXP = 1'b1;
`else
    localparam logic c_FAULT_EXP = 1'b0;
`endif

    elevator_plant #(
        .TRAVEL_CYCLES (8),
        .DOOR_CYCLES   (4),
        .START_FLOOR   (0)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .M          (M),
        .D          (D),
        .P          (P),
        .S0         (S0),
        .S1         (S1),
        .S2         (S2),
        .R          (R),
        .DoorClosed (DoorClosed),
        .Floor      (Floor),
        .Fault      (Fault)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on falling edges only
    task automatic step(input int n);
        repeat (n) @(negedge Clk);
    endtask

    initial begin
        Reset = 1'b0; M = 1'b0; D = 1'b0; P = 1'b0;
        step(2);
        Reset = 1'b1;
        step(1);
        check("rst_s0", S0, 1);
        check("rst_s1", S1, 0);
        check("rst_s2", S2, 0);
        check("rst_dc", DoorClosed, 1);
        check("rst_r", R, 0);
        check("rst_floor", Floor, 0);
        check("rst_fault", Fault, 0);

        // Bottom end stop: commanding down from floor 0 must not wrap
        M = 1'b1; D = 1'b0;
        step(2);
        check("clamp_lo_s0", S0, 1);
        check("clamp_lo_floor", Floor, 0);

        // Travel up from pos 0
        D = 1'b1;
        step(1); check("up_s0_drop", S0, 0);
        step(6); check("up_s1_early", S1, 0);
        step(1); check("up_s1", S1, 1);
                 check("up_floor1", Floor, 1);
        step(1); check("up_s1_leave", S1, 0);
                 check("up_floor_hold", Floor, 1);
        step(7); check("up_s2", S2, 1);
                 check("up_floor2", Floor, 2);
        step(3); check("clamp_hi_s2", S2, 1);

        // Back down to floor 1 and stop
        D = 1'b0;
        step(7); check("dn_s1_early", S1, 0);
        step(1); check("dn_s1", S1, 1);
        M = 1'b0;

        // OPEN timing: P seen by 4 edges only; the door still opens fully, then closes
        P = 1'b1;
        step(4);
        P = 1'b0;
        step(5); check("open_tmg_r_early", R, 0);
        step(1); check("open_tmg_r", R, 1);
                 check("open_tmg_dc", DoorClosed, 1);
        step(1); check("open_tmg_r_drop", R, 0);

        // Door cycle: P high for 10 cycles
        P = 1'b1;
        step(1); check("cyc_dc_low", DoorClosed, 0);
        step(9);
        P = 1'b0;
        step(4); check("cyc_r_early", R, 0);
                 check("cyc_dc_early", DoorClosed, 0);
        step(1); check("cyc_r", R, 1);
                 check("cyc_dc", DoorClosed, 1);
        step(1); check("cyc_r_drop", R, 0);

        // Reopen two cycles into CLOSING
        P = 1'b1;
        step(6);
        P = 1'b0;
        step(2);
        P = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1); check("reopen_no_r", R, 0);
        end
        P = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1); check("reclose_r_early", R, 0);
        end
        step(1); check("reclose_r", R, 1);

        // Interlock: motor command with the door OPEN
        P = 1'b1;
        step(5);
        M = 1'b1; D = 1'b1;
        step(1); check("ilk_fault", Fault, 32'(c_FAULT_EXP));
        step(2); check("ilk_s1", S1, 1);
                 check("ilk_s2", S2, 0);
                 check("ilk_floor", Floor, 1);
                 check("ilk_dc", DoorClosed, 0);
                 check("ilk_fault_sticky", Fault, 32'(c_FAULT_EXP));
        M = 1'b0; P = 1'b0;
        step(5); check("ilk_close_r", R, 1);
                 check("ilk_close_s1", S1, 1);

        // Simultaneous M and P at a floor: motion wins, door stays closed
        M = 1'b1; D = 1'b0; P = 1'b1;
        step(1); check("mp_dc", DoorClosed, 1);
                 check("mp_s1_drop", S1, 0);
        step(2);

        // Reset mid-travel between S0 and S1
        Reset = 1'b0; M = 1'b0; P = 1'b0;
        step(1);
        Reset = 1'b1;
        step(1);
        check("mid_rst_s0", S0, 1);
        check("mid_rst_s1", S1, 0);
        check("mid_rst_s2", S2, 0);
        check("mid_rst_floor", Floor, 0);
        check("mid_rst_r", R, 0);
        check("mid_rst_dc", DoorClosed, 1);
        check("mid_rst_fault", Fault, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
